conv_encoder_punct: RTL and testbench
=====================================

// Module: conv_encoder_punct
// PURPOSE
// - 802.11a transmit-side convolutional encoder (K=7, g0=133o, g1=171o) with tail insertion and puncturing.
// - Sits between the scrambler and the interleaver.
// - Emits 2-bit coded symbols {A,B} per cycle, matching the viterbi_decoder data_in pairing: [1]=A, [0]=B.
// PARAMETERS
// - DATA_NUM  36      data bits per frame; the 6 tail bits are extra
// - TAIL_NUM  6       zero tail bits appended (K-1)
// PORTS
// - Clk       in   1  clock, rising edge
// - reset     in   1  asynchronous, active-low reset
// - start     in   1  one-cycle pulse; begins a frame (IDLE only)
// - rate      in   2  00=1/2, 01=2/3, 10=3/4, 11=treated as 1/2; sampled on start
// - data_in   in   1  data bit
// - in_valid  in   1  data_in valid
// - in_ready  out  1  encoder accepts data_in this cycle
// - data_out  out  2  coded pair {A,B}; punctured positions forced to 0
// - out_mask  out  2  [1]=A kept, [0]=B kept
// - out_valid out  1  data_out/out_mask valid; no output backpressure
// - busy      out  1  frame in progress (DATA or TAIL)
// - done      out  1  one-cycle pulse with the last tail output
// BEHAVIOUR
// - Reset (any time, incl. mid-frame) clears all outputs, shift register, counters and phase; FSM -> IDLE.
// - FSM IDLE -> DATA on start: latch rate; clear sr[5:0]; clear bit_cnt and phase.
//   - start is ignored outside IDLE.
// - DATA: in_ready=1; each in_valid&in_ready consumes one bit.
//   - After DATA_NUM accepted bits -> TAIL.
//   - in_valid low stalls: no output, counters and phase hold.
// - TAIL: in_ready=0; inject one 0 bit per cycle for TAIL_NUM cycles, no stall.
//   - Then -> IDLE; done=1 on the final tail output cycle.
// - Window w[0]=current bit, w[k]=bit k steps ago (sr).
//   - A = w0^w2^w3^w5^w6
//   - B = w0^w1^w2^w3^w6
// - Latency: 1 cycle; data_out/out_valid registered the cycle after a bit is consumed or injected.
// - Puncture phase advances per encoded bit (data and tail alike) and wraps:
//   - 1/2: mask 11 always
//   - 2/3: 11,10 (period 2)
//   - 3/4: 11,10,01 (period 3)
// - data_out = {A&mask[1], B&mask[0]}.
// - out_valid is 1 even if a mask is partial; out_mask is 00 when out_valid=0.
// - Kept bits per frame (N=DATA_NUM+6=42): 84 at 1/2, 63 at 2/3, 56 at 3/4.
// - busy=1 from the cycle after start through the done cycle.
// - start on the same cycle as done: ignored (FSM not yet IDLE).
// TESTING
// - All-zero frame, rate 1/2 -> 42 out_valid cycles, data_out=00, mask=11, done on cycle 42.
// - Impulse rate 1/2 (1, then 35 zeros) -> data_out 11,01,11,11,00,10,11, then 00 to frame end.
// - Impulse rate 3/4 -> masks 11,10,01,... and data_out 11,00,01,11,00,00,11; sum of kept bits = 56.
// - Rate 2/3, random 36 bits with random in_valid gaps -> matches the gapless golden model;
//   kept bits = 63; no output on stall cycles.
// - Reset pulled low at data bit 20 -> outputs 0 at once; next frame from start encodes from zero state.
// - Loopback: encoder rate 1/2 -> viterbi_decoder -> its 36-bit data_out equals the input frame.

Source files
------------

// File: rtl/conv_encoder_punct.sv
// K=7 (133o/171o) convolutional encoder with zero tail and 1/2, 2/3, 3/4 puncturing; 1-cycle registered output.
// Input stalls via in_valid (in_ready only in DATA); output has no backpressure, one coded pair per consumed/injected bit.
module conv_encoder_punct #(
  parameter int DATA_NUM = 36,
  parameter int TAIL_NUM = 6
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] rate,
  input  logic       data_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] data_out,
  output logic [1:0] out_mask,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(DATA_NUM + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_TAIL  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       r_rate;
  logic [1:0]       r_phase;
  logic [5:0]       r_sr;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [1:0]       r_data_out;
  logic [1:0]       r_out_mask;
  logic             r_out_valid;

  logic       w_adv;
  logic       w_bit;
  logic       w_a;
  logic       w_b;
  logic [1:0] w_mask;
  logic [1:0] w_phase_nxt;
  logic [1:0] w_rate_eff;

  assign w_adv = ((r_state == ST_DATA) && in_valid) || (r_state == ST_TAIL);
  assign w_bit = (r_state == ST_DATA) ? data_in : 1'b0;

  // r_sr[k-1] holds the bit k steps ago
  assign w_a = w_bit ^ r_sr[1] ^ r_sr[2] ^ r_sr[4] ^ r_sr[5];
  assign w_b = w_bit ^ r_sr[0] ^ r_sr[1] ^ r_sr[2] ^ r_sr[5];

  assign w_rate_eff = (rate == 2'b11) ? 2'b00 : rate;

  always_comb begin
    w_mask      = 2'b11;
    w_phase_nxt = 2'd0;
    case (r_rate)
      2'b01: begin
        if (r_phase == 2'd1) w_mask = 2'b10;
        w_phase_nxt = (r_phase == 2'd1) ? 2'd0 : 2'd1;
      end
      2'b10: begin
        if (r_phase == 2'd1) w_mask = 2'b10;
        if (r_phase == 2'd2) w_mask = 2'b01;
        w_phase_nxt = (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
      end
      default: begin
        w_mask      = 2'b11;
        w_phase_nxt = 2'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_rate      <= 2'b00;
      r_phase     <= 2'd0;
      r_sr        <= 6'd0;
      r_bit_cnt   <= '0;
      r_data_out  <= 2'b00;
      r_out_mask  <= 2'b00;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_adv;
      r_data_out  <= w_adv ? {w_a & w_mask[1], w_b & w_mask[0]} : 2'b00;
      r_out_mask  <= w_adv ? w_mask : 2'b00;
      if (w_adv) begin
        r_sr    <= {r_sr[4:0], w_bit};
        r_phase <= w_phase_nxt;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_DATA;
            r_rate    <= w_rate_eff;
            r_sr      <= 6'd0;
            r_bit_cnt <= '0;
            r_phase   <= 2'd0;
          end
        end
        ST_DATA: begin
          if (in_valid) begin
            if (r_bit_cnt == CNT_W'(DATA_NUM - 1)) begin
              r_state   <= ST_TAIL;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_TAIL: begin
          if (r_bit_cnt == CNT_W'(TAIL_NUM - 1)) begin
            r_state   <= ST_FLUSH;
            r_bit_cnt <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          // last tail pair is on the outputs now; start stays ignored this cycle
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_DATA);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FLUSH);
  assign data_out  = r_data_out;
  assign out_mask  = r_out_mask;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Directed bench for conv_encoder_punct: reset state, hand-computed impulse responses, puncture masks,
// kept-bit totals, stalled input against a gapless reference, start-on-done, and mid-frame reset.
module tb_conv_encoder_punct;

  logic       Clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] rate;
  logic       data_in;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] data_out;
  logic [1:0] out_mask;
  logic       out_valid;
  logic       busy;
  logic       done;

  always #5 Clk = ~Clk;

  conv_encoder_punct #(.DATA_NUM(36), .TAIL_NUM(6)) dut (
    .Clk(Clk), .reset(reset), .start(start), .rate(rate),
    .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_mask(out_mask), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0] q_dat[$];
  logic [1:0] q_msk[$];
  int         done_idx;
  int         done_cnt;
  int         done_busy;
  int         bad_idle;
  logic       mon_en = 1'b0;

  logic [1:0] exp_dat[42];
  logic [1:0] exp_msk[42];

  always @(negedge Clk) begin
    if (mon_en) begin
      if (out_valid) begin
        q_dat.push_back(data_out);
        q_msk.push_back(out_mask);
      end else if (out_mask != 2'b00 || data_out != 2'b00) begin
        bad_idle++;
      end
      if (done) begin
        done_cnt++;
        done_idx = q_dat.size();
        if (busy) done_busy++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int kept();
    int s = 0;
    foreach (q_msk[i]) s += int'(q_msk[i][1]) + int'(q_msk[i][0]);
    return s;
  endfunction

  // Gapless reference: window w[0]=current bit, w[k]=bit k steps ago
  task automatic model(input logic [1:0] rt, input logic [35:0] bits);
    logic [6:0] w;
    logic       a, b;
    logic [1:0] m;
    int         per;
    w   = 7'd0;
    per = (rt == 2'b01) ? 2 : (rt == 2'b10) ? 3 : 1;
    for (int n = 0; n < 42; n++) begin
      w = {w[5:0], (n < 36) ? bits[n] : 1'b0};
      a = w[0] ^ w[2] ^ w[3] ^ w[5] ^ w[6];
      b = w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[6];
      case (n % per)
        1:       m = 2'b10;
        2:       m = 2'b01;
        default: m = 2'b11;
      endcase
      exp_msk[n] = m;
      exp_dat[n] = {a & m[1], b & m[0]};
    end
  endtask

  task automatic run_frame(input logic [1:0] rt, input logic [35:0] bits,
                           input bit gaps, input bit start_on_done);
    int   idx;
    int   guard;
    logic acc;
    q_dat.delete();
    q_msk.delete();
    done_idx  = -1;
    done_cnt  = 0;
    done_busy = 0;
    bad_idle  = 0;
    mon_en    = 1'b1;
    @(posedge Clk); #1;
    start = 1'b1;
    rate  = rt;
    @(posedge Clk); #1;
    start = 1'b0;
    rate  = ~rt;
    idx   = 0;
    guard = 0;
    while (idx < 36 && guard < 400) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      data_in  = bits[idx];
      acc      = in_valid && in_ready;
      @(posedge Clk); #1;
      if (acc) idx++;
      guard++;
    end
    if (idx < 36) chk("data_accept_timeout", 32'(idx), 32'd36);
    in_valid = 1'b0;
    data_in  = 1'b0;
    guard    = 0;
    while (!done && guard < 30) begin
      @(posedge Clk); #1;
      guard++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    if (start_on_done) start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    mon_en = 1'b0;
  endtask

  logic [1:0]  imp12[7];
  logic [1:0]  imp34[7];
  logic [35:0] rb;
  int          diffs;
  int          guard;

  initial begin
    imp12 = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10, 2'b11};
    imp34 = '{2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b11};
    reset = 1'b0; start = 1'b0; rate = 2'b00; data_in = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out",  32'(data_out),  32'd0);
    chk("rst_out_mask",  32'(out_mask),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    reset = 1'b1;
    @(posedge Clk); #1;

    // all-zero frame, rate 1/2
    run_frame(2'b00, 36'd0, 1'b0, 1'b0);
    chk("zero_count", 32'(q_dat.size()), 32'd42);
    diffs = 0;
    foreach (q_dat[i]) if (q_dat[i] != 2'b00 || q_msk[i] != 2'b11) diffs++;
    chk("zero_pairs_bad", 32'(diffs), 32'd0);
    chk("zero_done_idx",  32'(done_idx),  32'd42);
    chk("zero_done_cnt",  32'(done_cnt),  32'd1);
    chk("zero_done_busy", 32'(done_busy), 32'd1);
    chk("zero_idle_out",  32'(bad_idle),  32'd0);
    chk("zero_busy_end",  32'(busy),      32'd0);

    // impulse, rate 1/2
    run_frame(2'b00, 36'd1, 1'b0, 1'b0);
    chk("imp12_count", 32'(q_dat.size()), 32'd42);
    for (int i = 0; i < 7; i++) chk($sformatf("imp12_dat%0d", i), 32'(q_dat[i]), 32'(imp12[i]));
    diffs = 0;
    for (int i = 7; i < q_dat.size(); i++) if (q_dat[i] != 2'b00) diffs++;
    chk("imp12_tail_nonzero", 32'(diffs), 32'd0);
    chk("imp12_kept", 32'(kept()), 32'd84);

    // impulse, rate 3/4
    run_frame(2'b10, 36'd1, 1'b0, 1'b0);
    chk("imp34_count", 32'(q_dat.size()), 32'd42);
    chk("imp34_msk0", 32'(q_msk[0]), 32'd3);
    chk("imp34_msk1", 32'(q_msk[1]), 32'd2);
    chk("imp34_msk2", 32'(q_msk[2]), 32'd1);
    chk("imp34_msk3", 32'(q_msk[3]), 32'd3);
    for (int i = 0; i < 7; i++) chk($sformatf("imp34_dat%0d", i), 32'(q_dat[i]), 32'(imp34[i]));
    chk("imp34_kept", 32'(kept()), 32'd56);

    // rate 2/3, random data with input gaps against gapless reference
    rb[31:0]  = $urandom();
    rb[35:32] = 4'($urandom());
    model(2'b01, rb);
    run_frame(2'b01, rb, 1'b1, 1'b0);
    chk("r23_count", 32'(q_dat.size()), 32'd42);
    diffs = 0;
    for (int i = 0; i < 42 && i < q_dat.size(); i++)
      if (q_dat[i] !== exp_dat[i] || q_msk[i] !== exp_msk[i]) diffs++;
    chk("r23_diffs", 32'(diffs), 32'd0);
    chk("r23_kept", 32'(kept()), 32'd63);
    chk("r23_idle_out", 32'(bad_idle), 32'd0);
    chk("r23_done_idx", 32'(done_idx), 32'd42);

    // rate 11 behaves as 1/2; start asserted with done is ignored
    rb = 36'h9_A5C3_0F17;
    model(2'b00, rb);
    run_frame(2'b11, rb, 1'b0, 1'b1);
    diffs = 0;
    for (int i = 0; i < 42 && i < q_dat.size(); i++)
      if (q_dat[i] !== exp_dat[i] || q_msk[i] !== exp_msk[i]) diffs++;
    chk("r11_diffs", 32'(diffs), 32'd0);
    chk("r11_kept", 32'(kept()), 32'd84);
    chk("start_on_done_busy", 32'(busy), 32'd0);

    // reset asserted at data bit 20
    @(posedge Clk); #1;
    start = 1'b1; rate = 2'b00;
    @(posedge Clk); #1;
    start = 1'b0;
    in_valid = 1'b1; data_in = 1'b1;
    guard = 0;
    while (!(in_ready && out_valid && guard >= 20) && guard < 100) begin
      @(posedge Clk); #1;
      guard++;
    end
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_data_out",  32'(data_out),  32'd0);
    chk("mid_busy",      32'(busy),      32'd0);
    chk("mid_in_ready",  32'(in_ready),  32'd0);
    in_valid = 1'b0; data_in = 1'b0;
    @(posedge Clk); #1;
    reset = 1'b1;
    run_frame(2'b00, 36'd1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) chk($sformatf("post_rst_dat%0d", i), 32'(q_dat[i]), 32'(imp12[i]));
    chk("post_rst_count", 32'(q_dat.size()), 32'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
